// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch: assembles a big-endian 32-bit word from four byte reads,
// presents it to decode with a valid/ready handshake and honours redirects at any time.
module fetch_sequencer #(
    parameter int unsigned           WIDTH    = 32,
    parameter logic [WIDTH-1:0]      RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_en,
    output logic             mem_rd,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [7:0]       mem_rdata,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [WIDTH-1:0] instr_pc
);

    typedef enum logic [1:0] {
        StFetch,
        StLast,
        StValid
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic             rd_c;
    logic             valid_c;
    logic [WIDTH-1:0] addr_c;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        rd_c    = 1'b0;
        valid_c = 1'b0;
        addr_c  = pc_q;

        unique case (state_q)
            StFetch: begin
                // A started fetch (cnt != 0) runs to completion without fetch_en.
                if ((cnt_q != 2'd0) || fetch_en) begin
                    rd_c   = 1'b1;
                    addr_c = pc_q + WIDTH'(cnt_q);
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = StLast;
                    end
                end
                // Data returned this cycle belongs to the read issued at cnt_q - 1.
                case (cnt_q)
                    2'd1:    instr_d[31:24] = mem_rdata;
                    2'd2:    instr_d[23:16] = mem_rdata;
                    2'd3:    instr_d[15:8]  = mem_rdata;
                    default: ;
                endcase
            end
            StLast: begin
                instr_d[7:0] = mem_rdata;
                cnt_d        = 2'd0;
                state_d      = StValid;
            end
            StValid: begin
                valid_c = 1'b1;
                if (instr_ready) begin
                    pc_d    = pc_q + WIDTH'(4);
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
                cnt_d   = 2'd0;
            end
        endcase

        // Redirect wins over the handshake; a word handed over this cycle still counts.
        if (redirect) begin
            pc_d    = redirect_pc & ~WIDTH'(3);
            cnt_d   = 2'd0;
            state_d = StFetch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            cnt_q   <= 2'd0;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Outputs are forced to their reset values for the whole time rst is high.
    always_comb begin
        mem_rd      = rd_c & ~rst;
        mem_addr    = rst ? RESET_PC : addr_c;
        instr_valid = valid_c & ~rst;
        instr       = rst ? 32'd0 : instr_q;
        instr_pc    = rst ? RESET_PC : pc_q;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer (WIDTH=8): directed scenarios with literal
// expectations plus a randomized run compared every cycle against a behavioural model.
module tb_fetch_sequencer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         fetch_en;
    logic         mem_rd;
    logic [W-1:0] mem_addr;
    logic [7:0]   mem_rdata;
    logic         redirect;
    logic [W-1:0] redirect_pc;
    logic         instr_valid;
    logic         instr_ready;
    logic [31:0]  instr;
    logic [W-1:0] instr_pc;

    logic [7:0]   mem [256];
    int           n_checks;
    int           n_errors;
    int           hs40;

    // Model: progress of the current fetch as a step count (0 idle, 1-3 reading, 4 last byte
    // in flight, 5 word presented) and the word address; the word itself comes from memory.
    logic [W-1:0] m_pc;
    int           m_step;

    fetch_sequencer #(
        .WIDTH    (W),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem[mem_addr];

    function automatic logic [31:0] word(input logic [W-1:0] a);
        logic [W-1:0] a1, a2, a3;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        return {mem[a], mem[a1], mem[a2], mem[a3]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int lim);
        for (int i = 0; i < lim && !instr_valid; i++) tick();
        n_checks++;
        if (!instr_valid) begin
            n_errors++;
            $display("FAIL wait_valid: got instr_valid=0 expected 1 within %0d cycles", lim);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pc   = 8'h00;
            m_step = 0;
        end else if (redirect) begin
            m_pc   = redirect_pc & 8'hFC;
            m_step = 0;
        end else if (m_step == 5) begin
            if (instr_ready) begin
                m_pc   = m_pc + 8'd4;
                m_step = 0;
            end
        end else if (m_step == 0) begin
            if (fetch_en) m_step = 1;
        end else begin
            m_step = m_step + 1;
        end
        if (!rst && instr_valid && instr_ready && instr_pc == 8'h40) hs40++;
    end

    always @(negedge clk) begin
        logic         e_rd;
        logic         e_valid;
        logic [W-1:0] e_addr;
        e_rd    = !rst && ((m_step >= 1 && m_step <= 3) || (m_step == 0 && fetch_en));
        e_valid = !rst && (m_step == 5);
        e_addr  = rst ? 8'h00 : ((m_step <= 3) ? m_pc + 8'(m_step) : m_pc);
        chk("model_mem_rd", 32'(mem_rd), 32'(e_rd));
        chk("model_instr_valid", 32'(instr_valid), 32'(e_valid));
        if (e_rd || rst || m_step != 4) chk("model_mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_valid) begin
            chk("model_instr", instr, word(m_pc));
            chk("model_instr_pc", 32'(instr_pc), 32'(m_pc));
        end
        if (rst) begin
            chk("model_rst_instr", instr, 32'd0);
            chk("model_rst_instr_pc", 32'(instr_pc), 32'd0);
        end
    end

    initial begin
        logic [31:0] w;
        n_checks = 0;
        n_errors = 0;
        hs40 = 0;
        m_pc = 8'h00;
        m_step = 0;
        rst = 1'b1;
        fetch_en = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h00;
        mem[1] = 8'hA0;
        mem[2] = 8'h00;
        mem[3] = 8'h93;

        // Reset values
        repeat (2) tick();
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);

        // Basic fetch: first read in the first cycle after rst falls
        tick();
        rst = 1'b0;
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        #1;
        chk("basic_rd0", 32'(mem_rd), 32'd1);
        chk("basic_addr0", 32'(mem_addr), 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("basic_rd", 32'(mem_rd), 32'd1);
            chk("basic_addr", 32'(mem_addr), 32'(i));
        end
        tick();
        chk("basic_last_rd", 32'(mem_rd), 32'd0);
        chk("basic_last_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("basic_valid", 32'(instr_valid), 32'd1);
        chk("basic_instr", instr, 32'h00A00093);
        chk("basic_instr_pc", 32'(instr_pc), 32'd0);
        tick();
        instr_ready = 1'b0;
        #1;
        chk("basic_after_valid", 32'(instr_valid), 32'd0);
        chk("basic_next_rd", 32'(mem_rd), 32'd1);
        chk("basic_next_addr", 32'(mem_addr), 32'd4);

        // Backpressure
        wait_valid(10);
        w = instr;
        chk("bp_instr", w, word(8'h04));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_instr_stable", instr, w);
            chk("bp_pc_stable", 32'(instr_pc), 32'd4);
            chk("bp_no_rd", 32'(mem_rd), 32'd0);
            chk("bp_valid", 32'(instr_valid), 32'd1);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #1;
        chk("bp_hs_valid", 32'(instr_valid), 32'd0);
        chk("bp_hs_addr", 32'(mem_addr), 32'd8);

        // Redirect at cnt=2
        tick();
        tick();
        redirect = 1'b1;
        redirect_pc = 8'h43;
        tick();
        redirect = 1'b0;
        #1;
        chk("redir_rd", 32'(mem_rd), 32'd1);
        chk("redir_addr", 32'(mem_addr), 32'h40);
        wait_valid(10);
        chk("redir_instr_pc", 32'(instr_pc), 32'h40);
        chk("redir_instr", instr, word(8'h40));

        // Handshake and redirect together
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 8'h80;
        tick();
        redirect = 1'b0;
        instr_ready = 1'b0;
        #1;
        chk("hsredir_valid", 32'(instr_valid), 32'd0);
        chk("hsredir_addr", 32'(mem_addr), 32'h80);
        chk("hsredir_consumed_once", 32'(hs40), 32'd1);
        wait_valid(10);
        chk("hsredir_instr_pc", 32'(instr_pc), 32'h80);

        // Address wrap, then fetch_en gating
        redirect = 1'b1;
        redirect_pc = 8'hFE;
        tick();
        redirect = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("wrap_rd", 32'(mem_rd), 32'd1);
            chk("wrap_addr", 32'(mem_addr), 32'(8'hFC + i));
            tick();
        end
        tick();
        chk("wrap_valid", 32'(instr_valid), 32'd1);
        chk("wrap_instr_pc", 32'(instr_pc), 32'hFC);
        fetch_en = 1'b0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #1;
        chk("wrap_next_addr", 32'(mem_addr), 32'h00);
        for (int i = 0; i < 3; i++) begin
            chk("en_off_no_rd", 32'(mem_rd), 32'd0);
            tick();
        end
        fetch_en = 1'b1;
        #1;
        chk("en_on_rd", 32'(mem_rd), 32'd1);
        chk("en_on_addr", 32'(mem_addr), 32'd0);
        tick();
        fetch_en = 1'b0;
        #1;
        for (int i = 1; i < 4; i++) begin
            chk("en_mid_rd", 32'(mem_rd), 32'd1);
            chk("en_mid_addr", 32'(mem_addr), 32'(i));
            tick();
        end
        tick();
        chk("en_mid_valid", 32'(instr_valid), 32'd1);
        chk("en_mid_instr", instr, 32'h00A00093);

        // Reset while a word is held
        rst = 1'b1;
        #1;
        chk("rstv_valid", 32'(instr_valid), 32'd0);
        chk("rstv_instr", instr, 32'd0);
        tick();
        rst = 1'b0;
        fetch_en = 1'b1;
        #1;
        chk("rstv_after_valid", 32'(instr_valid), 32'd0);
        chk("rstv_after_instr", instr, 32'd0);
        chk("rstv_rd", 32'(mem_rd), 32'd1);
        chk("rstv_addr", 32'(mem_addr), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            fetch_en    = ($urandom % 10) < 8;
            instr_ready = ($urandom % 10) < 6;
            redirect    = ($urandom % 100) < 4;
            redirect_pc = 8'($urandom);
            rst         = ($urandom % 200) == 0;
        end
        tick();
        rst = 1'b0;
        redirect = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
